// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: two-flop synchronizer, counting debouncer,
// press/release edge pulses and an optional per-channel auto-repeat FSM.
module button_conditioner #(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] in,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic            pulse_any
);

  localparam int DB_MAX = (DEBOUNCE_CYCLES > 2) ? DEBOUNCE_CYCLES : 2;
  localparam int DB_W   = $clog2(DB_MAX);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam int RP_HI  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RP_MAX = (RP_HI > 2) ? RP_HI : 2;
  localparam int RP_W   = $clog2(RP_MAX);
  localparam logic [RP_W-1:0] DELAY_LAST  = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] PERIOD_LAST = RP_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rep_state_t;

  logic [N_CH-1:0]            sync1, sync2;
  logic [N_CH-1:0][DB_W-1:0]  db_cnt, db_cnt_d;
  logic [N_CH-1:0]            level_d, rise, fall;
  rep_state_t [N_CH-1:0]      state, state_d;
  logic [N_CH-1:0][RP_W-1:0]  rcnt, rcnt_d;
  logic [N_CH-1:0]            rep_fire, pulse_d;

  // Debouncer: count consecutive disagreeing cycles, accept the new level on the last one.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    db_cnt_d = db_cnt;
    level_d  = level;
    for (int i = 0; i < N_CH; i++) begin
      if (sync2[i] == level[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt[i] == DB_LAST) begin
        level_d[i]  = sync2[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt[i] + DB_W'(1);
      end
    end
    rise = level_d & ~level;
    fall = ~level_d & level;
  end

  // Repeat FSM next state; a falling level always wins over a due repeat pulse.
  always_comb begin
    state_d  = state;
    rcnt_d   = rcnt;
    rep_fire = '0;
    for (int i = 0; i < N_CH; i++) begin
      case (state[i])
        IDLE: begin
          if (rise[i]) begin
            state_d[i] = HOLD;
            rcnt_d[i]  = '0;
          end
        end
        HOLD: begin
          if (fall[i]) begin
            state_d[i] = IDLE;
          end else if (REPEAT_EN != 0) begin
            if (rcnt[i] == DELAY_LAST) begin
              rep_fire[i] = 1'b1;
              state_d[i]  = REPEAT;
              rcnt_d[i]   = '0;
            end else begin
              rcnt_d[i] = rcnt[i] + RP_W'(1);
            end
          end
        end
        REPEAT: begin
          if (fall[i]) begin
            state_d[i] = IDLE;
          end else if (rcnt[i] == PERIOD_LAST) begin
            rep_fire[i] = 1'b1;
            rcnt_d[i]   = '0;
          end else begin
            rcnt_d[i] = rcnt[i] + RP_W'(1);
          end
        end
        default: state_d[i] = IDLE;
      endcase
    end
    pulse_d = rise | rep_fire;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: all counters live in flops, not memories, so the async reset clears them in one step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1         <= '0;
      sync2         <= '0;
      db_cnt        <= '0;
      level         <= '0;
      pulse         <= '0;
      release_pulse <= '0;
      pulse_any     <= 1'b0;
      rcnt          <= '0;
    end else begin
      sync1         <= in;
      sync2         <= sync1;
      db_cnt        <= db_cnt_d;
      level         <= level_d;
      pulse         <= pulse_d;
      release_pulse <= fall;
      pulse_any     <= |pulse_d;
      rcnt          <= rcnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= {N_CH{IDLE}};
    else     state <= state_d;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: one instance with auto-repeat, one without,
// both driven by the same stimulus and checked against hand-derived cycle expectations.
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] in;
  logic [1:0] level, pulse, rel;
  logic       pany;
  logic [1:0] level0, pulse0, rel0;
  logic       pany0;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .N_CH(2), .DEBOUNCE_CYCLES(4), .REPEAT_EN(1), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk), .rst(rst), .in(in),
    .level(level), .pulse(pulse), .release_pulse(rel), .pulse_any(pany)
  );

  button_conditioner #(
    .N_CH(2), .DEBOUNCE_CYCLES(4), .REPEAT_EN(0), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut0 (
    .clk(clk), .rst(rst), .in(in),
    .level(level0), .pulse(pulse0), .release_pulse(rel0), .pulse_any(pany0)
  );

  // Advance one rising edge and settle just after it; inputs change and outputs are read here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in  = 2'b00;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in  = 2'b11;
    step();
    step();
    total++;
    if ({level, pulse, rel, pany} !== 7'b0) begin
      $display("FAIL reset_rep: got %b expected %b", {level, pulse, rel, pany}, 7'b0);
    end else passed++;
    total++;
    if ({level0, pulse0, rel0, pany0} !== 7'b0) begin
      $display("FAIL reset_norep: got %b expected %b", {level0, pulse0, rel0, pany0}, 7'b0);
    end else passed++;
    rst = 1'b0;
    in  = 2'b00;
    step();
  endtask

  // Press on channel 0 held from edge 0: level and pulse appear after edge 5, then release.
  task automatic test_press();
    do_reset();
    in = 2'b01;
    for (int s = 1; s <= 7; s++) begin
      logic [6:0] exp;
      step();
      exp = (s < 6) ? 7'b00_00_00_0 : (s == 6) ? 7'b01_01_00_1 : 7'b01_00_00_0;
      total++;
      if ({level, pulse, rel, pany} !== exp) begin
        $display("FAIL press_step%0d: got %b expected %b", s, {level, pulse, rel, pany}, exp);
      end else passed++;
    end
    in = 2'b00;
    for (int s = 1; s <= 7; s++) begin
      logic [6:0] exp;
      step();
      exp = (s < 6) ? 7'b01_00_00_0 : (s == 6) ? 7'b00_00_01_0 : 7'b00_00_00_0;
      total++;
      if ({level0, pulse0, rel0, pany0} !== exp) begin
        $display("FAIL release_step%0d: got %b expected %b", s, {level0, pulse0, rel0, pany0}, exp);
      end else passed++;
    end
  endtask

  // A 3-cycle blip is one cycle short of the debounce threshold and must vanish.
  task automatic test_glitch();
    do_reset();
    in = 2'b01;
    step();
    step();
    step();
    in = 2'b00;
    for (int s = 1; s <= 10; s++) begin
      step();
      total++;
      if ({level, pulse, rel, pany} !== 7'b0) begin
        $display("FAIL glitch_step%0d: got %b expected %b", s, {level, pulse, rel, pany}, 7'b0);
      end else passed++;
    end
  endtask

  // Hold channel 0 for 31 cycles: press at edge 5, repeats every 3 from edge 15;
  // the release lands on edge 36 where a repeat was due, so only release_pulse fires.
  task automatic test_repeat();
    do_reset();
    in = 2'b01;
    for (int s = 1; s <= 45; s++) begin
      int         e;
      logic       p, l, r, p0;
      logic [6:0] exp, exp0;
      step();
      e  = s - 1;
      p  = (e == 5) || (e >= 15 && e <= 33 && ((e - 15) % 3) == 0);
      p0 = (e == 5);
      l  = (e >= 5 && e <= 35);
      r  = (e == 36);
      exp  = {1'b0, l, 1'b0, p, 1'b0, r, p};
      exp0 = {1'b0, l, 1'b0, p0, 1'b0, r, p0};
      total++;
      if ({level, pulse, rel, pany} !== exp) begin
        $display("FAIL repeat_edge%0d: got %b expected %b", e, {level, pulse, rel, pany}, exp);
      end else passed++;
      total++;
      if ({level0, pulse0, rel0, pany0} !== exp0) begin
        $display("FAIL norepeat_edge%0d: got %b expected %b", e, {level0, pulse0, rel0, pany0}, exp0);
      end else passed++;
      if (s == 31) in = 2'b00;
    end
  endtask

  // Both channels press together; later channel 1 alone is released.
  task automatic test_simultaneous();
    do_reset();
    in = 2'b11;
    repeat (5) step();
    step();
    total++;
    if ({level, pulse, rel, pany} !== 7'b11_11_00_1) begin
      $display("FAIL simul_press: got %b expected %b", {level, pulse, rel, pany}, 7'b11_11_00_1);
    end else passed++;
    total++;
    if ({level0, pulse0, rel0, pany0} !== 7'b11_11_00_1) begin
      $display("FAIL simul_press0: got %b expected %b", {level0, pulse0, rel0, pany0}, 7'b11_11_00_1);
    end else passed++;
    in = 2'b01;
    repeat (5) step();
    total++;
    if ({level, pulse, rel, pany} !== 7'b11_00_00_0) begin
      $display("FAIL simul_prerelease: got %b expected %b", {level, pulse, rel, pany}, 7'b11_00_00_0);
    end else passed++;
    step();
    total++;
    if ({level, pulse, rel, pany} !== 7'b01_00_10_0) begin
      $display("FAIL simul_release1: got %b expected %b", {level, pulse, rel, pany}, 7'b01_00_10_0);
    end else passed++;
    step();
    total++;
    if ({level, pulse, rel, pany} !== 7'b01_00_00_0) begin
      $display("FAIL simul_after: got %b expected %b", {level, pulse, rel, pany}, 7'b01_00_00_0);
    end else passed++;
  endtask

  // Asynchronous clear of a held level, then a reset that interrupts a debounce.
  task automatic test_reset_mid();
    do_reset();
    in = 2'b01;
    repeat (7) step();
    #2 rst = 1'b1;
    #1;
    total++;
    if ({level, pulse, rel, pany} !== 7'b0) begin
      $display("FAIL async_clear: got %b expected %b", {level, pulse, rel, pany}, 7'b0);
    end else passed++;
    in = 2'b00;
    step();
    rst = 1'b0;
    repeat (10) step();
    in = 2'b01;
    step();
    step();
    rst = 1'b1;
    for (int s = 1; s <= 3; s++) begin
      step();
      total++;
      if ({level, pulse, rel, pany, level0, pulse0, rel0, pany0} !== 14'b0) begin
        $display("FAIL in_reset_step%0d: got %b expected %b", s,
                 {level, pulse, rel, pany, level0, pulse0, rel0, pany0}, 14'b0);
      end else passed++;
    end
    rst = 1'b0;
    for (int s = 1; s <= 7; s++) begin
      logic [6:0] exp;
      step();
      exp = (s < 6) ? 7'b00_00_00_0 : (s == 6) ? 7'b01_01_00_1 : 7'b01_00_00_0;
      total++;
      if ({level, pulse, rel, pany} !== exp) begin
        $display("FAIL post_reset_step%0d: got %b expected %b", s, {level, pulse, rel, pany}, exp);
      end else passed++;
    end
  endtask

  initial begin
    rst = 1'b1;
    in  = 2'b00;
    test_reset();
    test_press();
    test_glitch();
    test_repeat();
    test_simultaneous();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
